// File: rtl/data_checker.sv
// data_checker: aligns to the rotating 64-bit test pattern on a strobed serial
// stream, then reports lock, a pulse per mismatched bit and saturating error/bit counts.
module data_checker #(
   parameter logic [63:0] PATTERN     = 64'hB9A8_3120_7564_FDEC,
   parameter int          LOSS_THRESH = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic        serial_in,
   input  logic        data_flag,
   output logic        locked,
   output logic        err_pulse,
   output logic [15:0] err_count,
   output logic [31:0] bit_count
);
   // A sample is accepted in every cycle with enable && data_flag; there is no backpressure.
   typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;

   localparam logic [6:0] THRESH = 7'(LOSS_THRESH);

   state_t      state_q, state_d;
   logic [63:0] h_q, h_d, h_shift;
   logic [6:0]  fill_q, fill_d, fill_inc;
   logic [5:0]  ptr_q, ptr_d;
   logic [5:0]  win_cnt_q, win_cnt_d;
   logic [6:0]  win_err_q, win_err_d, win_err_inc;
   logic [15:0] err_count_q, err_count_d;
   logic [31:0] bit_count_q, bit_count_d;
   logic        err_pulse_q, err_pulse_d;
   logic        valid, mismatch, match;
   logic [5:0]  match_r;

   assign valid       = enable & data_flag;
   assign h_shift     = {h_q[62:0], serial_in};
   assign fill_inc    = (fill_q == 7'd64) ? 7'd64 : fill_q + 7'd1;
   assign mismatch    = serial_in ^ PATTERN[ptr_q];
   assign win_err_inc = win_err_q + {6'd0, mismatch};

   // Descending scan so the lowest matching rotation is the one left in match_r.
   always_comb begin : rot_search
      match   = 1'b0;
      match_r = 6'd0;
      for (int r = 63; r >= 0; r--) begin
         if (h_shift == ((PATTERN >> r) | (PATTERN << (64 - r)))) begin
            match   = 1'b1;
            match_r = 6'(r);
         end
      end
   end

   always_comb begin : next_state
      state_d     = state_q;
      h_d         = h_q;
      fill_d      = fill_q;
      ptr_d       = ptr_q;
      win_cnt_d   = win_cnt_q;
      win_err_d   = win_err_q;
      err_count_d = err_count_q;
      bit_count_d = bit_count_q;
      err_pulse_d = 1'b0;
      if (valid) begin
         h_d = h_shift;
         case (state_q)
            HUNT: begin
               fill_d = fill_inc;
               if ((fill_inc == 7'd64) && match) begin
                  state_d   = LOCKED;
                  ptr_d     = match_r - 6'd1;
                  win_cnt_d = 6'd0;
                  win_err_d = 7'd0;
               end
            end
            LOCKED: begin
               ptr_d     = ptr_q - 6'd1;
               win_cnt_d = win_cnt_q + 6'd1;
               if (bit_count_q != 32'hFFFF_FFFF) bit_count_d = bit_count_q + 32'd1;
               if (mismatch) begin
                  err_pulse_d = 1'b1;
                  if (err_count_q != 16'hFFFF) err_count_d = err_count_q + 16'd1;
               end
               // Threshold is tested before the window clear so a wrapping error still counts.
               if (win_err_inc >= THRESH) begin
                  state_d   = HUNT;
                  fill_d    = 7'd0;
                  win_cnt_d = 6'd0;
                  win_err_d = 7'd0;
               end else if (win_cnt_q == 6'd63) begin
                  win_err_d = 7'd0;
               end else begin
                  win_err_d = win_err_inc;
               end
            end
            default: state_d = HUNT;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= HUNT;
         h_q         <= 64'd0;
         fill_q      <= 7'd0;
         ptr_q       <= 6'd0;
         win_cnt_q   <= 6'd0;
         win_err_q   <= 7'd0;
         err_count_q <= 16'd0;
         bit_count_q <= 32'd0;
         err_pulse_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         h_q         <= h_d;
         fill_q      <= fill_d;
         ptr_q       <= ptr_d;
         win_cnt_q   <= win_cnt_d;
         win_err_q   <= win_err_d;
         err_count_q <= err_count_d;
         bit_count_q <= bit_count_d;
         err_pulse_q <= err_pulse_d;
      end
   end

   assign locked    = (state_q == LOCKED);
   assign err_pulse = err_pulse_q;
   assign err_count = err_count_q;
   assign bit_count = bit_count_q;

endmodule

// File: doc/data_checker.md
# data_checker

Receive-side companion to the bit-stream data generator. It consumes the serial test stream `serial_in`, which is qualified by the `data_flag` strobe, and aligns itself to the known 64-bit rotating test pattern. Once aligned, it compares every valid bit against the expected pattern bit and maintains lock, error and bit statistics. It sits at the end of the loopback/BER path, after demapping and parallel-to-serial conversion, and provides link-integrity status for the 16-QAM chain.

## Interface
- `PATTERN`, default 64'hB9A8_3120_7564_FDEC: test pattern, identical to the generator's seed.
- `LOSS_THRESH`, default 8: errors within one 64-sample window that force loss of lock (range 1..64).
- `clk` input 1: clock; all logic on rising edge.
- `rst` input 1: reset, synchronous, active-low.
- `enable` input 1: when low, samples are ignored and all state holds.
- `serial_in` input 1: received data bit.
- `data_flag` input 1: sample strobe. `serial_in` is valid in any cycle with `data_flag`=1 and `enable`=1. Back-to-back strobes are legal.
- `locked` output 1: pattern alignment achieved.
- `err_pulse` output 1: one-cycle pulse per mismatched sample while locked.
- `err_count` output 16: total mismatches while locked, saturating at 16'hFFFF.
- `bit_count` output 32: total samples checked while locked, saturating at 32'hFFFF_FFFF.

## Operation
- Transmit order of the pattern is P[0], P[63], P[62], …, P[1], P[0], … The bit index decrements mod 64.
- History register `h` (64 b) shifts on each valid sample: h <= {h[62:0], serial_in}.
- A fill counter (0..64) saturates at 64 and is cleared on entering HUNT.
- Two-state FSM: HUNT, LOCKED. Reset state is HUNT.
- HUNT behaviour:
  - Each valid sample shifts `h` and increments fill.
  - When the post-shift fill equals 64, the post-shift history is compared in parallel against all rotations rot_r = (P >> r) | (P << (64-r)), r = 0..63.
  - On any match, the lowest r wins, ptr <= (r-1) mod 64, and the FSM moves to LOCKED.
  - With no match, the FSM stays in HUNT. The window keeps sliding (fill stays 64) and the compare repeats on every later valid sample.
- LOCKED behaviour, for each valid sample:
  - mismatch = serial_in XOR P[ptr].
  - ptr <= ptr-1 mod 64; bit_count increments (saturating).
  - On mismatch: err_count increments (saturating), err_pulse is asserted, and the window error counter increments.
  - A window sample counter (6 b) wraps every 64 samples. At wrap, the window error counter is cleared; the wrapping sample's own error is counted before the clear.
  - If the window error counter reaches LOSS_THRESH, including via the current sample, the FSM goes to HUNT and fill and window counters are cleared. That sample is still counted in err_count and bit_count.
  - `h` keeps shifting in LOCKED, but it is not used there.
- `err_count` and `bit_count` are never cleared by loss of lock. Only reset clears them.
- Samples seen in HUNT never affect err_count or bit_count.
- With `enable`=0, `data_flag` is ignored and no register changes.

## Timing
- Reset values: `locked`=0, `err_pulse`=0, `err_count`=0, `bit_count`=0. Also: FSM=HUNT, ptr=0, h=0, all internal counters 0.
- Reset mid-operation: all of the above take effect at the next rising edge and override any simultaneous `data_flag`.
- `locked` rises in the cycle after the 64th qualifying valid sample in HUNT. The very next valid sample is checked, even if it arrives back-to-back.
- `locked` falls in the cycle after the sample that reaches LOSS_THRESH.
- `err_pulse` and the counter updates appear in the cycle after the offending valid sample. `err_pulse` lasts exactly one cycle per error.
- All outputs are registered; there are no combinational input-to-output paths.

## Test plan
- **Initial lock:** after reset, drive 64 correct bits starting at index 0, one strobe every 1020 cycles. Required: `locked` goes to 1 one cycle after the 64th strobe; err_count=0; bit_count=0.
- **Error-free run:** while locked, 100 further correct bits, back-to-back strobes. Required: bit_count=100, err_count=0, err_pulse never asserted.
- **Single error:** invert the 10th locked bit. Required: err_pulse high for exactly 1 cycle; err_count=1; `locked` stays 1; later bits compare correctly.
- **Loss of lock and relock:** inject LOSS_THRESH=8 errors within one window. Required: `locked` goes to 0 after the 8th error; err_count=8. Then feed 64 correct bits starting at index 37. Required: relock, and the following correct bits add no errors.
- **Window and saturation boundaries:**
  - 7 errors, then a window wrap, then 7 more errors. Required: `locked` stays 1.
  - Force err_count to 16'hFFFF and inject an error. Required: err_count holds at 16'hFFFF.
- **Enable and reset:**
  - `enable`=0 with 5 strobes. Required: counters and state unchanged.
  - Assert `rst`=0 while locked. Required: all outputs are 0 at the next edge, and lock needs 64 new samples to return.
